// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, decoded-word layout
// and the decode helpers used by the decode stage.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int REG_SEL_W  = 3;
  localparam int NUM_REGS   = 1 << REG_SEL_W;
  localparam int IMM_W      = 8;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 9;
  localparam int RA_MSB     = 7;
  localparam int RA_LSB     = 5;
  localparam int RB_MSB     = 4;
  localparam int RB_LSB     = 2;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_OR     = 4'd2,
    OP_XOR    = 4'd3,
    OP_AND    = 4'd4,
    OP_NOT    = 4'd5,
    OP_READ   = 4'd6,
    OP_WRITE  = 4'd7,
    OP_LOAD   = 4'd8,
    OP_CMP    = 4'd9,
    OP_SHL    = 4'd10,
    OP_SHR    = 4'd11,
    OP_JUMP   = 4'd12,
    OP_JUMPEQ = 4'd13,
    OP_RSVD14 = 4'd14,
    OP_RSVD15 = 4'd15
  } opcode_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stageState_t;

  typedef struct packed {
    logic [REG_SEL_W-1:0] selA;
    logic [REG_SEL_W-1:0] selB;
    logic [REG_SEL_W-1:0] selD;
    logic                 we;
    logic [OPCODE_W-1:0]  aluop;
    logic [IMM_W-1:0]     imm;
    logic                 illegal;
  } decoded_t;

  // Stores, jumps and the two reserved opcodes leave the register file untouched.
  function automatic logic writesRd(input opcode_t op);
    case (op)
      OP_WRITE, OP_JUMP, OP_JUMPEQ, OP_RSVD14, OP_RSVD15: return 1'b0;
      default:                                            return 1'b1;
    endcase
  endfunction

  function automatic logic isIllegal(input opcode_t op);
    return (op == OP_RSVD14) || (op == OP_RSVD15);
  endfunction

  function automatic decoded_t decodeInstr(input logic [INSTR_W-1:0] instr);
    decoded_t d;
    opcode_t  op;
    op        = opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
    d.aluop   = instr[OPCODE_MSB:OPCODE_LSB];
    d.selD    = instr[RD_MSB:RD_LSB];
    d.selA    = instr[RA_MSB:RA_LSB];
    d.selB    = instr[RB_MSB:RB_LSB];
    d.imm     = instr[IMM_MSB:IMM_LSB];
    d.we      = writesRd(op);
    d.illegal = isIllegal(op);
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// RAW-hazard scoreboard: one pending bit per architectural register, set when a
// writing instruction is accepted and cleared by register-file writeback.
module decode_scoreboard
  import cpu_pkg::*;
(
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_valid,
  input  logic [REG_SEL_W-1:0] I_selA,
  input  logic [REG_SEL_W-1:0] I_selB,
  input  logic [REG_SEL_W-1:0] I_selD,
  input  logic                 I_we,
  input  logic                 I_accept,
  input  logic                 I_wb_en,
  input  logic [REG_SEL_W-1:0] I_wb_sel,
  output logic                 o_stall
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (I_accept && I_we) setMask[I_selD] = 1'b1;
    if (I_wb_en)          clrMask[I_wb_sel] = 1'b1;
  end

  // NOTE: pending is control state, not a data array, so it must be reset.
  // A set and a clear hitting the same register leaves it set: the new writer wins.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clrMask) | setMask;
    end
  end

  // Uses the registered bits only, so a same-cycle writeback releases the stall next cycle.
  assign o_stall = I_valid &&
                   (pending[I_selA] || pending[I_selB] || (I_we && pending[I_selD]));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: single-entry registered decoder with a valid/ready handshake.
// Define DECODE_SCOREBOARD_EN to compile in the RAW-hazard scoreboard stall.
module decode_stage
  import cpu_pkg::*;
(
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic [INSTR_W-1:0]   I_instr,
  input  logic                 I_valid,
  output logic                 o_ready,
  input  logic                 I_ready,
  output logic                 o_valid,
  output logic [REG_SEL_W-1:0] o_selA,
  output logic [REG_SEL_W-1:0] o_selB,
  output logic [REG_SEL_W-1:0] o_selD,
  output logic                 o_we,
  output logic [OPCODE_W-1:0]  o_aluop,
  output logic [IMM_W-1:0]     o_imm,
  output logic                 o_illegal,
  input  logic                 I_wb_en,
  input  logic [REG_SEL_W-1:0] I_wb_sel
);

  stageState_t state;
  decoded_t    decoded;
  decoded_t    outReg;
  logic        stall;
  logic        accept;

  always_comb decoded = decodeInstr(I_instr);

  assign o_ready = ((state == ST_EMPTY) || I_ready) && !stall;
  assign accept  = I_valid && o_ready;

`ifdef DECODE_SCOREBOARD_EN
  decode_scoreboard u_scoreboard (
    .I_clk    (I_clk),
    .I_rst_n  (I_rst_n),
    .I_valid  (I_valid),
    .I_selA   (decoded.selA),
    .I_selB   (decoded.selB),
    .I_selD   (decoded.selD),
    .I_we     (decoded.we),
    .I_accept (accept),
    .I_wb_en  (I_wb_en),
    .I_wb_sel (I_wb_sel),
    .o_stall  (stall)
  );
`else
  assign stall = 1'b0;
  logic unusedWb;
  assign unusedWb = ^{I_wb_en, I_wb_sel};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state  <= ST_EMPTY;
      outReg <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state  <= ST_FULL;
            outReg <= decoded;
          end
        end
        ST_FULL: begin
          // accept here already implies I_ready, so the old entry has been consumed.
          if (accept) begin
            outReg <= decoded;
          end else if (I_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign o_valid   = (state == ST_FULL);
  assign o_selA    = outReg.selA;
  assign o_selB    = outReg.selB;
  assign o_selD    = outReg.selD;
  assign o_we      = outReg.we;
  assign o_aluop   = outReg.aluop;
  assign o_imm     = outReg.imm;
  assign o_illegal = outReg.illegal;

endmodule
